piso_tx: RTL
============

# piso_tx

Parallel-in/serial-out transmitter with a one-word holding buffer and a valid/ready load handshake. It is the transmit end of the team's serial link; the receive end is the `sipo` deserializer. It accepts WIDTH-bit words from upstream logic and emits them one bit per clock with framing strobes. Back-to-back words stream with no idle gap between them.

## Interface
- `WIDTH`, default 4: word width in bits. Legal range is 2 or more.
- `MSB_FIRST`, default 1: 1 transmits bit WIDTH-1 first; 0 transmits bit 0 first.

- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset: asynchronous assert, active-low.
- `din`  input  WIDTH  parallel word to transmit.
- `load_valid`  input  1  upstream has a word on `din`.
- `load_ready`  output  1  block can accept a word; equals NOT hold_full.
- `serial_out`  output  1  current serial bit; 0 whenever `serial_valid` is 0.
- `serial_valid`  output  1  `serial_out` carries a data bit this cycle.
- `sof`  output  1  high on the first bit of each word.
- `eof`  output  1  high on the last bit of each word.

## Operation
- Internal state:
  - shift register `shreg` [WIDTH].
  - bit counter `cnt`, width clog2(WIDTH).
  - `active` flag (state IDLE = 0, SHIFT = 1).
  - holding register `hold` [WIDTH] with `hold_full` flag.
- Accept: the word is accepted on a rising edge where `load_valid` and `load_ready` are both 1. `din` is ignored at every other time.
- Routing of an accepted word:
  - IDLE, or SHIFT with cnt == WIDTH-1 (last bit), and hold empty: load directly into `shreg`. Set active=1, cnt=0.
  - SHIFT with cnt < WIDTH-1: write into `hold`. Set hold_full=1.
- Last bit handling (SHIFT, cnt == WIDTH-1) at the edge:
  - hold_full: `shreg` takes `hold`, hold_full clears, cnt=0, active stays 1.
  - else, accept in progress: word loads directly, as above.
  - else: active=0 (back to IDLE).
- Any other SHIFT cycle: `shreg` shifts one position toward the output end and cnt increments.
- Simultaneous accept with hold_full cannot occur, because `load_ready` is 0 in that case.
- Outputs:
  - `serial_out` = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0], gated by `active`.
  - `serial_valid` = active.
  - `sof` = active AND cnt==0.
  - `eof` = active AND cnt==WIDTH-1.
- Reset (any time, including mid-word): clears `shreg`, `hold`, `cnt`, `active` and `hold_full` asynchronously. Any partially sent word and any held word are discarded, with no residual bits after release.

## Timing
- Reset values: `serial_out`=0, `serial_valid`=0, `sof`=0, `eof`=0, `load_ready`=1.
- Latency: a word accepted at edge E from IDLE presents its first bit in the cycle after E. The last bit is WIDTH-1 cycles later.
- Each word occupies exactly WIDTH consecutive cycles of `serial_valid`=1.
- Throughput: one word per WIDTH cycles sustained, with zero gap when the next word is accepted before or during the current last bit.
- `load_ready` behaviour:
  - Drops the cycle after a word enters `hold`.
  - Rises the cycle after the last bit that transfers `hold` into `shreg`.
- All outputs are registered or decoded from registers only. There is no combinational path from `din` or `load_valid` to any output except `load_ready`, and `load_ready` does not depend on `load_valid`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles, then release. Required response: all outputs 0 and `load_ready`=1 before any load.
- Single word, WIDTH=4, MSB_FIRST=1, `din`=4'b1011 accepted at edge E. Required response:
  - `serial_out` is 1,0,1,1 on cycles E+1 through E+4.
  - `sof` at E+1 only, `eof` at E+4 only.
  - `serial_valid` is 0 from E+5.
- Back-to-back: 4'b1011, then 4'b0110 offered with `load_valid` held. Required response:
  - Contiguous stream 1,0,1,1,0,1,1,0 with `serial_valid` high for 8 cycles.
  - `sof` on bits 1 and 5.
  - `load_ready` low while the second word sits in `hold`.
- LSB-first (MSB_FIRST=0), 4'b1011. Required response: stream 1,1,0,1.
- Backpressure: with `hold` full, drive `load_valid`=1 and change `din` every cycle. Required response: no extra word is accepted, and the transmitted data matches only the two accepted words.
- Reset mid-word: pull `rst_n` low after 2 bits of 4'b1011 while `hold` holds 4'b0110. Required response:
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, no bits appear until a new accept.
  - Looping `serial_out` into a `sipo` receiver reproduces each accepted word on its `q` after WIDTH bits.

Source files
------------

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with a one-word holding buffer.
// Words stream out one bit per clock with sof/eof framing and no gap between back-to-back words.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             sof,
    output logic             eof
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    cnt;
    logic             hold_full;

    logic             active;
    logic             accept;
    logic             last_bit;
    logic             head_bit;

    assign active   = (state == SHIFT);
    assign accept   = load_valid & ~hold_full;
    assign last_bit = active && (cnt == LAST);
    assign head_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    // Every output is decoded from registers, so reset clears them without waiting for a clock.
    assign load_ready   = ~hold_full;
    assign serial_valid = active;
    assign serial_out   = active & head_bit;
    assign sof          = active && (cnt == '0);
    assign eof          = last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            hold      <= '0;
            cnt       <= '0;
            hold_full <= 1'b0;
        end else if (!active) begin
            if (accept) begin
                shreg <= din;
                cnt   <= '0;
                state <= SHIFT;
            end
        end else if (last_bit) begin
            // The held word takes priority; hold_full also blocks any new accept this cycle.
            if (hold_full) begin
                shreg     <= hold;
                hold_full <= 1'b0;
                cnt       <= '0;
            end else if (accept) begin
                shreg <= din;
                cnt   <= '0;
            end else begin
                state <= IDLE;
            end
        end else begin
            if (MSB_FIRST) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
            cnt <= cnt + CW'(1);
            if (accept) begin
                hold      <= din;
                hold_full <= 1'b1;
            end
        end
    end

endmodule
